// File: rtl/button_debounce_if.sv
// Button conditioner bus: raw pad inputs in, debounced pulses and levels out.
interface button_debounce_if;
    logic btn_l_raw;
    logic btn_r_raw;
    logic left;
    logic right;
    logic left_level;
    logic right_level;

    // Driver of the raw buttons, consumer of the conditioned outputs.
    modport master (
        output btn_l_raw,
        output btn_r_raw,
        input  left,
        input  right,
        input  left_level,
        input  right_level
    );

    // The debouncer itself.
    modport slave (
        input  btn_l_raw,
        input  btn_r_raw,
        output left,
        output right,
        output left_level,
        output right_level
    );
endinterface

// File: rtl/button_debounce.sv
// Two-channel button synchroniser/debouncer producing a one-cycle press pulse
// and a debounced level per channel (channel 0 = left, channel 1 = right).
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 16,
    parameter int unsigned RPT_W           = 7
`endif
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);

    localparam int unsigned NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] level;

    assign raw = {bus.btn_r_raw, bus.btn_l_raw};

    assign bus.left        = pulse[0];
    assign bus.right       = pulse[1];
    assign bus.left_level  = level[0];
    assign bus.right_level = level[1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             sync1;
        logic             sync2;
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             press_c;
        logic             pulse_nxt;
        logic             pulse_q;
        logic             level_nxt;
        logic             level_q;

        // Two-flop synchroniser for the asynchronous pad input.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
            end
        end

        // Debounce state, counter and registered outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                pulse_q <= pulse_nxt;
                level_q <= level_nxt;
            end
        end

        // Next-state logic: a change is accepted after DEBOUNCE_CYCLES stable samples.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            press_c   = 1'b0;
            level_nxt = level_q;
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (sync2) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        press_c   = 1'b1;
                        level_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    cnt_nxt = '0;
                    if (!sync2) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt;
        logic [RPT_W-1:0] rpt_nxt;
        logic             rep_mode;
        logic             rep_mode_nxt;
        logic             rpt_fire;

        // Repeat timer: first repeat after HOLD_CYCLES, then every REPEAT_CYCLES;
        // it only advances while staying in HELD, so it freezes in RELEASE_WAIT.
        always_comb begin
            rpt_nxt      = rpt;
            rep_mode_nxt = rep_mode;
            rpt_fire     = 1'b0;
            if ((state == IDLE) || press_c) begin
                rpt_nxt      = '0;
                rep_mode_nxt = 1'b0;
            end else if ((state == HELD) && sync2) begin
                if (!rep_mode && (rpt == RPT_W'(HOLD_CYCLES - 1))) begin
                    rpt_fire     = 1'b1;
                    rpt_nxt      = '0;
                    rep_mode_nxt = 1'b1;
                end else if (rep_mode && (rpt == RPT_W'(REPEAT_CYCLES - 1))) begin
                    rpt_fire = 1'b1;
                    rpt_nxt  = '0;
                end else begin
                    rpt_nxt = rpt + RPT_W'(1);
                end
            end
        end

        // Repeat timer registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                rpt      <= '0;
                rep_mode <= 1'b0;
            end else begin
                rpt      <= rpt_nxt;
                rep_mode <= rep_mode_nxt;
            end
        end

        assign pulse_nxt = press_c | rpt_fire;
`else
        assign pulse_nxt = press_c;
`endif

        assign pulse[i] = pulse_q;
        assign level[i] = level_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: table of constant-input segments
// with expected pulse/level edges, plus a long-hold sequence (auto-repeat aware).
module tb_button_debounce;

    logic clk;
    logic rst;

    button_debounce_if bif ();

    button_debounce dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One segment: inputs held for len edges; edge indices are 1-based within
    // the segment, 0 means "no event".
    typedef struct {
        logic rst;
        logic l;
        logic r;
        int   len;
        int   lp;
        int   rp;
        logic ll0;
        int   lle;
        logic rl0;
        int   rle;
    } seg_t;

    typedef struct {
        logic left;
        logic right;
        logic ll;
        logic rl;
        int   seg;
        int   edge_no;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rs, input logic l, input logic r, input int len,
                       input int lp, input int rp, input logic ll0, input int lle,
                       input logic rl0, input int rle);
        seg_t s;
        s.rst = rs; s.l = l; s.r = r; s.len = len;
        s.lp = lp; s.rp = rp; s.ll0 = ll0; s.lle = lle; s.rl0 = rl0; s.rle = rle;
        segs.push_back(s);
    endtask

    task automatic check(input string name, input int seg, input int e,
                         input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s seg %0d edge %0d: got %b expected %b", name, seg, e, act, expv);
        end
    endtask

    // Drive one edge worth of inputs, queue the expectation, compare after the edge.
    task automatic run_edge(input logic rs, input logic l, input logic r, input exp_t x);
        exp_t got;
        rst = rs;
        bif.btn_l_raw = l;
        bif.btn_r_raw = r;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("left",        got.seg, got.edge_no, bif.left,        got.left);
        check("right",       got.seg, got.edge_no, bif.right,       got.right);
        check("left_level",  got.seg, got.edge_no, bif.left_level,  got.ll);
        check("right_level", got.seg, got.edge_no, bif.right_level, got.rl);
    endtask

    initial begin
        exp_t x;
        rst = 1'b1;
        bif.btn_l_raw = 1'b0;
        bif.btn_r_raw = 1'b0;

        // reset, then idle
        add(1, 0, 0,  3,  0,  0, 0,  0, 0,  0);
        add(0, 0, 0, 50,  0,  0, 0,  0, 0,  0);
        // clean left press and release
        add(0, 1, 0, 40, 18,  0, 0, 18, 0,  0);
        add(0, 0, 0, 20,  0,  0, 1, 18, 0,  0);
        // bouncy left press: 4x (5 high, 3 low), then steady high
        for (int b = 0; b < 4; b++) begin
            add(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
            add(0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        end
        add(0, 1, 0, 30, 18,  0, 0, 18, 0,  0);
        // release glitch while held, then real release
        add(0, 0, 0, 10,  0,  0, 1,  0, 0,  0);
        add(0, 1, 0, 10,  0,  0, 1,  0, 0,  0);
        add(0, 0, 0, 20,  0,  0, 1, 18, 0,  0);
        // right-only press and release
        add(0, 0, 1, 25,  0, 18, 0,  0, 0, 18);
        add(0, 0, 0, 20,  0,  0, 0,  0, 1, 18);
        // simultaneous press and release
        add(0, 1, 1, 30, 18, 18, 0, 18, 0, 18);
        add(0, 0, 0, 20,  0,  0, 1, 18, 1, 18);
        // second press interrupted by reset at its edge 10, held through reset
        add(0, 1, 1,  9,  0,  0, 0,  0, 0,  0);
        add(1, 1, 1,  2,  0,  0, 0,  0, 0,  0);
        add(0, 1, 1, 25, 18, 18, 0, 18, 0, 18);
        add(0, 0, 0, 20,  0,  0, 1, 18, 1, 18);

        foreach (segs[si]) begin
            for (int k = 1; k <= segs[si].len; k++) begin
                x.left    = (k == segs[si].lp);
                x.right   = (k == segs[si].rp);
                x.ll      = (segs[si].lle != 0 && k >= segs[si].lle) ? !segs[si].ll0 : segs[si].ll0;
                x.rl      = (segs[si].rle != 0 && k >= segs[si].rle) ? !segs[si].rl0 : segs[si].rl0;
                x.seg     = si;
                x.edge_no = k;
                run_edge(segs[si].rst, segs[si].l, segs[si].r, x);
            end
        end

        // long right hold: press pulse at edge 18, repeats only with auto-repeat
        for (int k = 1; k <= 200; k++) begin
            x.left  = 1'b0;
            x.ll    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            x.right = (k == 18) || (k >= 18 + 64 && ((k - (18 + 64)) % 16) == 0);
`else
            x.right = (k == 18);
`endif
            x.rl      = (k >= 18);
            x.seg     = 100;
            x.edge_no = k;
            run_edge(1'b0, 1'b0, 1'b1, x);
        end
        // release after the long hold: level falls, no further pulses
        for (int k = 1; k <= 20; k++) begin
            x.left    = 1'b0;
            x.ll      = 1'b0;
            x.right   = 1'b0;
            x.rl      = (k < 18);
            x.seg     = 101;
            x.edge_no = k;
            run_edge(1'b0, 1'b0, 1'b0, x);
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
